// File: rtl/io_loader_if.sv
// io_loader_if
//   Bundles the board-side inputs and the memory I/O port signals that the
//   io_loader sequencer drives.
//
//   Switch     board switches (half-word data source)
//   Btn_lo     raw button: latch Switch into data[15:0]
//   Btn_hi     raw button: latch Switch into data[31:16]
//   Btn_write  raw button: write word (EDIT) / step address (VIEW)
//   Btn_mode   raw button: toggle EDIT <-> VIEW
//   NumtoEx    read data returned by the I/O port
//   AddfromEx  byte address to the I/O port
//   NumfromEx  write data to the I/O port
//   Stop_en    1 = VIEW (read) mode
//   Verify_en  single-cycle write strobe
//   Display    value shown on the board
//
//   master: the io_loader side.  slave: the board / I/O port side.
interface io_loader_if;
    logic [15:0] Switch;
    logic        Btn_lo;
    logic        Btn_hi;
    logic        Btn_write;
    logic        Btn_mode;
    logic [31:0] NumtoEx;
    logic [31:0] AddfromEx;
    logic [31:0] NumfromEx;
    logic        Stop_en;
    logic        Verify_en;
    logic [31:0] Display;

    modport master (
        input  Switch, Btn_lo, Btn_hi, Btn_write, Btn_mode, NumtoEx,
        output AddfromEx, NumfromEx, Stop_en, Verify_en, Display
    );

    modport slave (
        output Switch, Btn_lo, Btn_hi, Btn_write, Btn_mode, NumtoEx,
        input  AddfromEx, NumfromEx, Stop_en, Verify_en, Display
    );
endinterface

// File: rtl/io_loader.sv
// io_loader
//   Board-side input sequencer in front of the CPU memory I/O port. Debounces
//   four buttons, assembles a 32-bit word from two switch half-words, writes
//   it to memory word by word (EDIT) or steps through memory to read it back
//   (VIEW).
//
//   CLK      system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      io_loader_if.master: switches/buttons/read data in,
//            address/write data/Stop_en/Verify_en/Display out
module io_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [31:0] BASE_ADDR       = 32'd0,
    parameter logic [31:0] ADDR_LIMIT      = 32'd128
) (
    input  logic          CLK,
    input  logic          Reset_n,
    io_loader_if.master   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_EDIT  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_VIEW  = 2'd2;

    // Button index: 0 lo, 1 hi, 2 write, 3 mode
    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       acc_q, acc_d;
    logic [3:0]       evt;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] disp_q, disp_d;
    logic        stop_q, verify_q;

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == ADDR_LIMIT - 32'd4) ? BASE_ADDR : a + 32'd4;
    endfunction

    assign raw = {bus.Btn_mode, bus.Btn_write, bus.Btn_hi, bus.Btn_lo};

    // The event fires in the cycle the accepted level commits to 1, so the
    // FSM acts on the same clock edge that updates the accepted level.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = '0;
            evt[i]   = 1'b0;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    acc_d[i] = sync2_q[i];
                    evt[i]   = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Mode beats write; lo/hi still latch alongside a mode event in EDIT.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_EDIT: begin
                if (evt[0]) data_d[15:0]  = bus.Switch;
                if (evt[1]) data_d[31:16] = bus.Switch;
                if (evt[3]) begin
                    state_d = S_VIEW;
                    addr_d  = BASE_ADDR;
                end else if (evt[2]) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_EDIT;
                addr_d  = next_addr(addr_q);
            end
            S_VIEW: begin
                if (evt[3]) begin
                    state_d = S_EDIT;
                    addr_d  = BASE_ADDR;
                end else if (evt[2]) begin
                    addr_d = next_addr(addr_q);
                end
            end
            default: begin
                state_d = S_EDIT;
                addr_d  = BASE_ADDR;
            end
        endcase
        // Display register samples the read port every cycle while in VIEW.
        disp_d = (state_d == S_VIEW) ? bus.NumtoEx : data_d;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_EDIT;
            addr_q   <= BASE_ADDR;
            data_q   <= '0;
            disp_q   <= '0;
            stop_q   <= 1'b0;
            verify_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            disp_q   <= disp_d;
            stop_q   <= (state_d == S_VIEW);
            verify_q <= (state_d == S_WRITE);
        end
    end

    assign bus.AddfromEx = addr_q;
    assign bus.NumfromEx = data_q;
    assign bus.Stop_en   = stop_q;
    assign bus.Verify_en = verify_q;
    assign bus.Display   = disp_q;

endmodule

// File: tb/tb_io_loader.sv
module tb_io_loader;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int GAP  = 12;
    localparam int LAT  = DEB + 2;

    logic CLK = 1'b0;
    logic Reset_n = 1'b1;
    always #5 CLK = ~CLK;

    io_loader_if bus();

    io_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .BASE_ADDR      (32'd0),
        .ADDR_LIMIT     (32'd128)
    ) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .bus    (bus.master)
    );

    // Memory emulation behind the I/O port (combinational read).
    logic [31:0] emu_mem [32];
    logic        mem_clr = 1'b1;
    logic        use_emu = 1'b1;
    logic [31:0] nt_force = 32'h0;

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) emu_mem[i] <= 32'h0;
        end else if (bus.Verify_en) begin
            emu_mem[bus.AddfromEx[6:2]] <= bus.NumfromEx;
        end
    end

    always_comb begin
        bus.NumtoEx = use_emu ? emu_mem[bus.AddfromEx[6:2]] : nt_force;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Transaction-level reference model.
    logic        m_view;
    logic [31:0] m_addr, m_data;
    logic [31:0] m_mem [32];

    task automatic model_reset();
        m_view = 1'b0;
        m_addr = 32'd0;
        m_data = 32'd0;
    endtask

    task automatic model_apply(input logic [3:0] m, input logic [15:0] sw,
                               output int exp_n, output logic [31:0] exp_sa);
        exp_n  = 0;
        exp_sa = 32'd0;
        if (!m_view) begin
            if (m[0]) m_data[15:0]  = sw;
            if (m[1]) m_data[31:16] = sw;
            if (m[3]) begin
                m_view = 1'b1;
                m_addr = 32'd0;
            end else if (m[2]) begin
                exp_n  = 1;
                exp_sa = m_addr;
                m_mem[m_addr[6:2]] = m_data;
                m_addr = (m_addr + 32'd4) % 32'd128;
            end
        end else begin
            if (m[3]) begin
                m_view = 1'b0;
                m_addr = 32'd0;
            end else if (m[2]) begin
                m_addr = (m_addr + 32'd4) % 32'd128;
            end
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        bus.Btn_lo    = m[0];
        bus.Btn_hi    = m[1];
        bus.Btn_write = m[2];
        bus.Btn_mode  = m[3];
    endtask

    // Clean press: hold HOLD cycles, release, idle GAP cycles. Called at a negedge.
    task automatic do_press(input logic [3:0] m, input logic [15:0] sw,
                            output int n, output int off, output logic [31:0] sa,
                            output logic [31:0] sd, output logic [31:0] sdisp,
                            output int vbad);
        n = 0; off = -1; sa = 0; sd = 0; sdisp = 0; vbad = 0;
        bus.Switch = sw;
        set_btns(m);
        for (int c = 1; c <= HOLD + GAP; c++) begin
            @(negedge CLK);
            if (bus.Verify_en) begin
                n++;
                if (bus.Stop_en) vbad++;
                if (off < 0) begin
                    off   = c;
                    sa    = bus.AddfromEx;
                    sd    = bus.NumfromEx;
                    sdisp = bus.Display;
                end
            end
            if (c == HOLD) set_btns(4'b0000);
        end
    endtask

    typedef struct {
        logic [3:0]  m;
        logic [15:0] sw;
        int          n;
        logic [31:0] sa;
        logic [31:0] addr;
        logic [31:0] nfe;
        logic        stop;
        logic [31:0] disp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int          n, off, vbad, exp_n, cnt, cnt2, found;
        logic [31:0] sa, sd, sdisp, exp_sa;
        logic [3:0]  m;
        logic [15:0] sw;

        tbl[0] = '{4'b0001, 16'h1234, 0, 32'h0, 32'h0, 32'h00001234, 1'b0, 32'h00001234};
        tbl[1] = '{4'b0010, 16'hABCD, 0, 32'h0, 32'h0, 32'hABCD1234, 1'b0, 32'hABCD1234};
        tbl[2] = '{4'b0100, 16'h0000, 1, 32'h0, 32'h4, 32'hABCD1234, 1'b0, 32'hABCD1234};
        tbl[3] = '{4'b1000, 16'h0000, 0, 32'h0, 32'h0, 32'hABCD1234, 1'b1, 32'hABCD1234};
        tbl[4] = '{4'b0100, 16'h0000, 0, 32'h0, 32'h4, 32'hABCD1234, 1'b1, 32'h00000000};
        tbl[5] = '{4'b0001, 16'h5555, 0, 32'h0, 32'h4, 32'hABCD1234, 1'b1, 32'h00000000};
        tbl[6] = '{4'b1100, 16'h0000, 0, 32'h0, 32'h0, 32'hABCD1234, 1'b0, 32'hABCD1234};
        tbl[7] = '{4'b1001, 16'h7777, 0, 32'h0, 32'h0, 32'hABCD7777, 1'b1, 32'hABCD1234};
        tbl[8] = '{4'b1000, 16'h0000, 0, 32'h0, 32'h0, 32'hABCD7777, 1'b0, 32'hABCD7777};

        bus.Switch = 16'h0;
        set_btns(4'b0000);

        // Power-on reset
        #1 Reset_n = 1'b0;
        #2;
        chk("por_addr",   bus.AddfromEx, 32'h0);
        chk("por_nfe",    bus.NumfromEx, 32'h0);
        chk("por_stop",   32'(bus.Stop_en), 32'h0);
        chk("por_verify", 32'(bus.Verify_en), 32'h0);
        chk("por_disp",   bus.Display, 32'h0);
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
        mem_clr = 1'b0;
        @(negedge CLK);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            do_press(tbl[v].m, tbl[v].sw, n, off, sa, sd, sdisp, vbad);
            chk($sformatf("tbl%0d_strobes", v), 32'(n), 32'(tbl[v].n));
            if (tbl[v].n == 1) begin
                chk($sformatf("tbl%0d_strobe_off", v), 32'(off), 32'(LAT));
                chk($sformatf("tbl%0d_strobe_addr", v), sa, tbl[v].sa);
                chk($sformatf("tbl%0d_strobe_data", v), sd, tbl[v].nfe);
                chk($sformatf("tbl%0d_strobe_disp", v), sdisp, tbl[v].nfe);
            end
            chk($sformatf("tbl%0d_addr", v), bus.AddfromEx, tbl[v].addr);
            chk($sformatf("tbl%0d_nfe", v),  bus.NumfromEx, tbl[v].nfe);
            chk($sformatf("tbl%0d_stop", v), 32'(bus.Stop_en), 32'(tbl[v].stop));
            chk($sformatf("tbl%0d_disp", v), bus.Display, tbl[v].disp);
        end

        // VIEW read path: forced read data shows one cycle later
        do_press(4'b1000, 16'h0, n, off, sa, sd, sdisp, vbad);
        chk("view_stop", 32'(bus.Stop_en), 32'h1);
        use_emu  = 1'b0;
        nt_force = 32'hDEADBEEF;
        @(negedge CLK);
        chk("view_deadbeef", bus.Display, 32'hDEADBEEF);
        do_press(4'b1000, 16'h0, n, off, sa, sd, sdisp, vbad);
        use_emu = 1'b1;
        chk("view_exit_stop", 32'(bus.Stop_en), 32'h0);

        // Bounce, then a clean hold
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            bus.Btn_write = ((c / 2) % 2 == 0);
            @(negedge CLK);
            if (bus.Verify_en) cnt++;
        end
        chk("bounce_strobes", 32'(cnt), 32'h0);
        bus.Btn_write = 1'b1;
        cnt = 0; off = -1; sa = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge CLK);
            if (bus.Verify_en) begin
                cnt++;
                if (off < 0) begin off = c; sa = bus.AddfromEx; end
            end
        end
        bus.Btn_write = 1'b0;
        repeat (GAP) @(negedge CLK);
        chk("hold_strobes", 32'(cnt), 32'h1);
        chk("hold_off", 32'(off), 32'(LAT));
        chk("hold_addr", sa, 32'h0);
        chk("hold_next_addr", bus.AddfromEx, 32'h4);

        // Reset mid-run with all buttons held
        bus.Switch = 16'hFFFF;
        set_btns(4'b1111);
        repeat (7) @(negedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_addr",   bus.AddfromEx, 32'h0);
        chk("rst_nfe",    bus.NumfromEx, 32'h0);
        chk("rst_stop",   32'(bus.Stop_en), 32'h0);
        chk("rst_verify", 32'(bus.Verify_en), 32'h0);
        chk("rst_disp",   bus.Display, 32'h0);
        set_btns(4'b0000);
        @(negedge CLK);
        Reset_n = 1'b1;
        cnt = 0; cnt2 = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.Verify_en) cnt++;
            if (bus.Stop_en) cnt2++;
        end
        chk("idle_verify", 32'(cnt), 32'h0);
        chk("idle_stop", 32'(cnt2), 32'h0);
        chk("idle_addr", bus.AddfromEx, 32'h0);

        // Address wrap over 32 writes
        model_reset();
        for (int i = 0; i < 32; i++) begin
            model_apply(4'b0100, 16'h0, exp_n, exp_sa);
            do_press(4'b0100, 16'h0, n, off, sa, sd, sdisp, vbad);
            chk($sformatf("wrap%0d_strobes", i), 32'(n), 32'h1);
            chk($sformatf("wrap%0d_addr", i), sa, 32'(4 * i));
        end
        chk("wrap_final_addr", bus.AddfromEx, 32'h0);

        // Reset during the WRITE cycle
        do_press(4'b0100, 16'h0, n, off, sa, sd, sdisp, vbad);
        chk("pre_wr_addr", bus.AddfromEx, 32'h4);
        bus.Btn_write = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge CLK);
            if (bus.Verify_en) found = 1;
        end
        chk("wrrst_strobe_seen", 32'(found), 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        chk("wrrst_verify", 32'(bus.Verify_en), 32'h0);
        chk("wrrst_addr", bus.AddfromEx, 32'h0);
        bus.Btn_write = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (12) @(negedge CLK);
        chk("wrrst_after_addr", bus.AddfromEx, 32'h0);
        chk("wrrst_after_stop", 32'(bus.Stop_en), 32'h0);
        model_reset();
        model_apply(4'b0001, 16'h5A5A, exp_n, exp_sa);
        do_press(4'b0001, 16'h5A5A, n, off, sa, sd, sdisp, vbad);
        chk("wrrst_edit_nfe", bus.NumfromEx, m_data);
        chk("wrrst_edit_disp", bus.Display, m_data);

        // Randomized presses against the model
        mem_clr = 1'b1;
        @(negedge CLK);
        mem_clr = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: m = 4'b0001;
                1: m = 4'b0010;
                2: m = 4'b0011;
                3, 4: m = 4'b0100;
                5: m = 4'b1000;
                6: m = 4'b1100;
                default: m = 4'($urandom_range(0, 15));
            endcase
            sw = 16'($urandom);
            model_apply(m, sw, exp_n, exp_sa);
            do_press(m, sw, n, off, sa, sd, sdisp, vbad);
            chk($sformatf("rnd%0d_strobes", i), 32'(n), 32'(exp_n));
            chk($sformatf("rnd%0d_vstop", i), 32'(vbad), 32'h0);
            if (exp_n == 1) begin
                chk($sformatf("rnd%0d_off", i), 32'(off), 32'(LAT));
                chk($sformatf("rnd%0d_saddr", i), sa, exp_sa);
                chk($sformatf("rnd%0d_sdata", i), sd, m_data);
            end
            chk($sformatf("rnd%0d_addr", i), bus.AddfromEx, m_addr);
            chk($sformatf("rnd%0d_nfe", i), bus.NumfromEx, m_data);
            chk($sformatf("rnd%0d_stop", i), 32'(bus.Stop_en), 32'(m_view));
            chk($sformatf("rnd%0d_disp", i), bus.Display,
                m_view ? m_mem[m_addr[6:2]] : m_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
